// File: rtl/tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo_arbiter
// Purpose  : Round-robin read controller for the two transmit-side lane FIFOs
//            of phy_tx. Pops at most one word per clk_2f cycle from either
//            FIFO 0 or FIFO 1, caps consecutive pops from one channel at
//            BURST_LEN while the other channel has data, and stalls on
//            downstream backpressure. Exactly one registered word (with its
//            source channel) is presented per cycle to the 2:1 lane mux.
//
// Ports    : clk_2f           - single clock, rising-edge
//            reset            - synchronous, active-high
//            fifo_empty_0/1   - FWFT empty flags of FIFO 0 / FIFO 1
//            fifo_data_0/1    - head words of FIFO 0 / FIFO 1
//            dest_almost_full - downstream backpressure, blocks pops
//            pop_0/1          - combinational read strobes to the FIFOs
//            data_out         - registered word to the mux
//            valid_out        - registered qualifier for data_out
//            channel_out      - registered source channel of data_out
//            state_out        - FSM state for debug (IDLE=0, SERVE_0=1,
//                               SERVE_1=2)
//
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4    // legal range 1..15
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic                  fifo_empty_0,
    input  logic                  fifo_empty_1,
    input  logic [DATA_WIDTH-1:0] fifo_data_0,
    input  logic [DATA_WIDTH-1:0] fifo_data_1,
    input  logic                  dest_almost_full,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  channel_out,
    output logic [1:0]            state_out
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SERVE_0 = 2'd1;
    localparam logic [1:0] c_SERVE_1 = 2'd2;

    // Count value at which the current pop is the last of a burst.
    localparam logic [3:0] c_BURST_LAST = 4'(BURST_LEN - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [3:0]            r_burst_cnt;
    logic [3:0]            w_burst_cnt_nxt;
    logic                  r_last_ch;
    logic                  w_last_ch_nxt;

    logic                  w_pop_0;
    logic                  w_pop_1;
    logic [1:0]            w_state_out;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_channel_out;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_burst_cnt <= 4'd0;
            // Pretend channel 1 was served last so channel 0 wins the
            // first tie after reset.
            r_last_ch   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_last_ch   <= w_last_ch_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        w_last_ch_nxt   = r_last_ch;

        case (r_state)
            c_IDLE: begin
                // Grant decision only; the first pop happens in the SERVE
                // state, which costs one bubble cycle here.
                if (!dest_almost_full) begin
                    if (!fifo_empty_0 && (fifo_empty_1 || r_last_ch)) begin
                        w_state_nxt     = c_SERVE_0;
                        w_burst_cnt_nxt = 4'd0;
                        w_last_ch_nxt   = 1'b0;
                    end else if (!fifo_empty_1) begin
                        w_state_nxt     = c_SERVE_1;
                        w_burst_cnt_nxt = 4'd0;
                        w_last_ch_nxt   = 1'b1;
                    end
                end
            end

            c_SERVE_0: begin
                // Backpressure freezes state and burst count.
                if (!dest_almost_full) begin
                    if (!fifo_empty_0) begin
                        if (r_burst_cnt == c_BURST_LAST) begin
                            // Burst exhausted: hand over only if the other
                            // channel is waiting, otherwise start a fresh
                            // burst on this one.
                            w_burst_cnt_nxt = 4'd0;
                            if (!fifo_empty_1) begin
                                w_state_nxt   = c_SERVE_1;
                                w_last_ch_nxt = 1'b1;
                            end
                        end else begin
                            w_burst_cnt_nxt = r_burst_cnt + 4'd1;
                        end
                    end else if (!fifo_empty_1) begin
                        w_state_nxt     = c_SERVE_1;
                        w_burst_cnt_nxt = 4'd0;
                        w_last_ch_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end

            c_SERVE_1: begin
                if (!dest_almost_full) begin
                    if (!fifo_empty_1) begin
                        if (r_burst_cnt == c_BURST_LAST) begin
                            w_burst_cnt_nxt = 4'd0;
                            if (!fifo_empty_0) begin
                                w_state_nxt   = c_SERVE_0;
                                w_last_ch_nxt = 1'b0;
                            end
                        end else begin
                            w_burst_cnt_nxt = r_burst_cnt + 4'd1;
                        end
                    end else if (!fifo_empty_0) begin
                        w_state_nxt     = c_SERVE_0;
                        w_burst_cnt_nxt = 4'd0;
                        w_last_ch_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end

            default: begin
                // Unused encoding: recover to IDLE.
                w_state_nxt     = c_IDLE;
                w_burst_cnt_nxt = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // Pops are gated by reset so that a reset cycle never consumes a word.
    // Since only one SERVE state is active at a time the strobes are
    // mutually exclusive by construction.
    // ------------------------------------------------------------------
    always_comb begin
        w_pop_0     = (r_state == c_SERVE_0) && !fifo_empty_0 &&
                      !dest_almost_full && !reset;
        w_pop_1     = (r_state == c_SERVE_1) && !fifo_empty_1 &&
                      !dest_almost_full && !reset;
        w_state_out = r_state;
    end

    // ------------------------------------------------------------------
    // Output register: one cycle after the pop the word appears here.
    // data_out/channel_out hold their last value when nothing is popped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_data_out    <= '0;
            r_valid_out   <= 1'b0;
            r_channel_out <= 1'b0;
        end else if (w_pop_0) begin
            r_data_out    <= fifo_data_0;
            r_valid_out   <= 1'b1;
            r_channel_out <= 1'b0;
        end else if (w_pop_1) begin
            r_data_out    <= fifo_data_1;
            r_valid_out   <= 1'b1;
            r_channel_out <= 1'b1;
        end else begin
            r_valid_out   <= 1'b0;
        end
    end

    assign pop_0       = w_pop_0;
    assign pop_1       = w_pop_1;
    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign channel_out = r_channel_out;
    assign state_out   = w_state_out;

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_fifo_arbiter
// Purpose  : Directed self-checking bench for tx_fifo_arbiter. Two queue
//            based FWFT FIFO models feed the arbiter; every valid output
//            word is logged with its cycle number and compared against
//            hand-computed sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_arbiter;

    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN  = 4;

    logic                  clk_2f = 1'b0;
    logic                  reset = 1'b1;
    logic                  fifo_empty_0 = 1'b1;
    logic                  fifo_empty_1 = 1'b1;
    logic [DATA_WIDTH-1:0] fifo_data_0 = '0;
    logic [DATA_WIDTH-1:0] fifo_data_1 = '0;
    logic                  dest_almost_full = 1'b0;
    logic                  pop_0;
    logic                  pop_1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  channel_out;
    logic [1:0]            state_out;

    tx_fifo_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_dut (
        .clk_2f           (clk_2f),
        .reset            (reset),
        .fifo_empty_0     (fifo_empty_0),
        .fifo_empty_1     (fifo_empty_1),
        .fifo_data_0      (fifo_data_0),
        .fifo_data_1      (fifo_data_1),
        .dest_almost_full (dest_almost_full),
        .pop_0            (pop_0),
        .pop_1            (pop_1),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .channel_out      (channel_out),
        .state_out        (state_out)
    );

    always #5 clk_2f = ~clk_2f;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int start    = 0;

    typedef struct {
        int         c;
        logic       ch;
        logic [7:0] d;
    } word_t;

    word_t      got_q[$];
    word_t      exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       s_pop_0;
    logic       s_pop_1;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void refresh_fifos();
        fifo_empty_0 = (q0.size() == 0);
        fifo_empty_1 = (q1.size() == 0);
        fifo_data_0  = (q0.size() > 0) ? q0[0] : 8'h00;
        fifo_data_1  = (q1.size() > 0) ? q1[0] : 8'h00;
    endfunction

    // Expected word at a cycle offset relative to the scenario start.
    function automatic void exp_word(input int off, input logic ch, input logic [7:0] d);
        word_t w;
        w.c  = off;
        w.ch = ch;
        w.d  = d;
        exp_q.push_back(w);
    endfunction

    task automatic compare_stream(input string tag);
        check_value({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check_value($sformatf("%s_cyc%0d", tag, i), 32'(got_q[i].c - start), 32'(exp_q[i].c));
                check_value($sformatf("%s_ch%0d", tag, i), 32'(got_q[i].ch), 32'(exp_q[i].ch));
                check_value($sformatf("%s_data%0d", tag, i), 32'(got_q[i].d), 32'(exp_q[i].d));
            end
        end
        exp_q.delete();
    endtask

    // Cycle counter
    always @(posedge clk_2f) cyc <= cyc + 1;

    // FIFO models plus continuous protocol checks. Strobes are sampled at
    // the edge and the queues are updated just after it.
    always @(posedge clk_2f) begin
        s_pop_0 = pop_0;
        s_pop_1 = pop_1;
        check_value("pop_mutex", 32'(pop_0 & pop_1), 32'd0);
        check_value("pop0_while_empty", 32'(pop_0 & fifo_empty_0), 32'd0);
        check_value("pop1_while_empty", 32'(pop_1 & fifo_empty_1), 32'd0);
        check_value("pop_while_backpressure", 32'((pop_0 | pop_1) & dest_almost_full), 32'd0);
        check_value("pop_while_reset", 32'((pop_0 | pop_1) & reset), 32'd0);
        #1;
        if (s_pop_0 && q0.size() > 0) void'(q0.pop_front());
        if (s_pop_1 && q1.size() > 0) void'(q1.pop_front());
        refresh_fifos();
    end

    // Output logger
    always @(negedge clk_2f) begin
        if (valid_out) begin
            word_t w;
            w.c  = cyc;
            w.ch = channel_out;
            w.d  = data_out;
            got_q.push_back(w);
        end
    end

    task automatic do_reset();
        @(negedge clk_2f);
        reset            = 1'b1;
        dest_almost_full = 1'b0;
        q0.delete();
        q1.delete();
        refresh_fifos();
        repeat (2) @(negedge clk_2f);
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic begin_scenario();
        refresh_fifos();
        got_q.delete();
        start = cyc;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset values
        repeat (3) @(negedge clk_2f);
        check_value("rst_state", 32'(state_out), 32'd0);
        check_value("rst_valid", 32'(valid_out), 32'd0);
        check_value("rst_data", 32'(data_out), 32'd0);
        check_value("rst_channel", 32'(channel_out), 32'd0);
        check_value("rst_pops", 32'({pop_0, pop_1}), 32'd0);
        reset = 1'b0;

        // Scenario 1: three words in FIFO 0 only
        q0.push_back(8'hA1); q0.push_back(8'hA2); q0.push_back(8'hA3);
        begin_scenario();
        exp_word(2, 1'b0, 8'hA1);
        exp_word(3, 1'b0, 8'hA2);
        exp_word(4, 1'b0, 8'hA3);
        repeat (7) @(negedge clk_2f);
        compare_stream("s1");
        check_value("s1_end_state", 32'(state_out), 32'd0);
        check_value("s1_end_valid", 32'(valid_out), 32'd0);
        check_value("s1_hold_data", 32'(data_out), 32'hA3);
        check_value("s1_hold_channel", 32'(channel_out), 32'd0);

        // Scenario 2: both FIFOs hold six words, burst alternation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(8'(8'h10 + i));
            q1.push_back(8'(8'h20 + i));
        end
        begin_scenario();
        for (int i = 0; i < 4; i++) exp_word(2 + i, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) exp_word(6 + i, 1'b1, 8'(8'h20 + i));
        exp_word(10, 1'b0, 8'h14);
        exp_word(11, 1'b0, 8'h15);
        exp_word(13, 1'b1, 8'h24);
        exp_word(14, 1'b1, 8'h25);
        repeat (18) @(negedge clk_2f);
        compare_stream("s2");
        check_value("s2_end_state", 32'(state_out), 32'd0);

        // Scenario 3: FIFO 0 has 2 words, FIFO 1 has 5
        do_reset();
        q0.push_back(8'h30); q0.push_back(8'h31);
        for (int i = 0; i < 5; i++) q1.push_back(8'(8'h40 + i));
        begin_scenario();
        exp_word(2, 1'b0, 8'h30);
        exp_word(3, 1'b0, 8'h31);
        for (int i = 0; i < 5; i++) exp_word(5 + i, 1'b1, 8'(8'h40 + i));
        repeat (12) @(negedge clk_2f);
        compare_stream("s3");
        check_value("s3_end_state", 32'(state_out), 32'd0);

        // Scenario 4: backpressure for three cycles mid-burst
        do_reset();
        for (int i = 0; i < 6; i++) q0.push_back(8'(8'h50 + i));
        for (int i = 0; i < 4; i++) q1.push_back(8'(8'h60 + i));
        begin_scenario();
        exp_word(2, 1'b0, 8'h50);
        exp_word(3, 1'b0, 8'h51);
        exp_word(7, 1'b0, 8'h52);
        exp_word(8, 1'b0, 8'h53);
        for (int i = 0; i < 4; i++) exp_word(9 + i, 1'b1, 8'(8'h60 + i));
        exp_word(13, 1'b0, 8'h54);
        exp_word(14, 1'b0, 8'h55);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk_2f);
            if (i == 3) begin
                check_value("s4_pop_before_bp", 32'(pop_0), 32'd1);
                dest_almost_full = 1'b1;
                #1;
                check_value("s4_pop_blocked", 32'(pop_0), 32'd0);
            end
            if (i >= 4 && i <= 6) begin
                check_value($sformatf("s4_bp_valid%0d", i), 32'(valid_out), 32'd0);
                check_value($sformatf("s4_bp_pop%0d", i), 32'(pop_0), 32'd0);
                check_value($sformatf("s4_bp_state%0d", i), 32'(state_out), 32'd1);
            end
            if (i == 6) dest_almost_full = 1'b0;
        end
        compare_stream("s4");
        check_value("s4_end_state", 32'(state_out), 32'd0);

        // Scenario 5: reset pulse during the SERVE_1 burst
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'(8'h70 + i));
            q1.push_back(8'(8'h80 + i));
        end
        begin_scenario();
        for (int i = 0; i < 4; i++) exp_word(2 + i, 1'b0, 8'(8'h70 + i));
        exp_word(6, 1'b1, 8'h80);
        exp_word(7, 1'b1, 8'h81);
        exp_word(10, 1'b0, 8'h74);
        exp_word(12, 1'b1, 8'h82);
        exp_word(13, 1'b1, 8'h83);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_2f);
            if (i == 7) begin
                check_value("s5_state_serve1", 32'(state_out), 32'd2);
                check_value("s5_pop1_before_rst", 32'(pop_1), 32'd1);
                reset = 1'b1;
                #1;
                check_value("s5_pop1_in_rst", 32'(pop_1), 32'd0);
            end
            if (i == 8) begin
                check_value("s5_rst_state", 32'(state_out), 32'd0);
                check_value("s5_rst_valid", 32'(valid_out), 32'd0);
                check_value("s5_rst_data", 32'(data_out), 32'd0);
                check_value("s5_rst_channel", 32'(channel_out), 32'd0);
                reset = 1'b0;
                q0.push_back(8'h74);
                refresh_fifos();
            end
        end
        compare_stream("s5");
        check_value("s5_end_state", 32'(state_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
